// File: rtl/riscv_fetch.sv
//==============================================================================
// Module      : riscv_fetch
// Description : Instruction fetch stage. Owns the fetch PC and issues word
//               reads to instruction memory over a valid/ready channel. It
//               buffers in-order responses as {pc, inst} pairs in a small
//               FIFO and presents the FIFO head to decode. A redirect flushes
//               the FIFO and restarts fetch at the new target.
// Optional    : RISCV_FETCH_ALIGN_CHECK_EN - a misaligned redirect parks the
//               stage in FAULT (fault_out=1) until an aligned redirect.
// Ports       : clk_in, rst_in            clock / sync active-high reset
//               redirect_valid_in/pc_in   flush and restart fetch
//               imem_req_*                request channel (valid/ready/addr)
//               imem_resp_*               in-order response data
//               inst_valid_out/ready_in   decode handshake
//               inst_out, pc_out          head instruction and its PC
//               fault_out                 misaligned-redirect fault
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module riscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fault_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_START = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
`endif

  state_t          state;
  state_t          state_next;

  logic [31:0]     fetch_pc;
  logic [31:0]     resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic [31:0]     inst_mem [FIFO_DEPTH];

  logic [31:0]     redirect_pc;
  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            misaligned;

  // Target is always word-aligned; the low bits only matter for fault detection.
  assign redirect_pc = {redirect_pc_in[31:2], 2'b00};

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  assign misaligned = |redirect_pc_in[1:0];
  assign fault_out  = (state == ST_FAULT);
`else
  logic unused_align;
  assign unused_align = ^redirect_pc_in[1:0];
  assign misaligned   = 1'b0;
  assign fault_out    = 1'b0;
`endif

  // Credit: every outstanding request has a reserved FIFO slot, so a response
  // can always be pushed. The sum never grows while a request is pending,
  // which keeps valid/addr stable until accepted.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign req_valid   = (state == ST_RUN) && !redirect_valid_in && (credit_used < DEPTH_W);
  assign req_fire    = req_valid && imem_req_ready_in;
  assign push        = imem_resp_valid_in && !redirect_valid_in && (discard == '0);
  assign pop         = inst_valid_out && inst_ready_in && !redirect_valid_in;

  assign imem_req_valid_out = req_valid;
  assign imem_req_addr_out  = fetch_pc;
  assign inst_valid_out     = (count != '0);
  assign inst_out           = inst_mem[rd_ptr];
  assign pc_out             = pc_mem[rd_ptr];

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_START;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect overrides whatever the current state wants.
  always_comb begin
    state_next = state;
    case (state)
      ST_START: state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
      ST_FAULT: state_next = ST_FAULT;
`endif
      default:  state_next = ST_START;
    endcase
    if (redirect_valid_in) begin
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
      state_next = misaligned ? ST_FAULT : ST_RUN;
`else
      state_next = misaligned ? ST_START : ST_RUN;
`endif
    end
  end

  // PC tracking, outstanding/discard bookkeeping and FIFO storage
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_valid_in) begin
      // Everything still in flight after this cycle's (dropped) response
      // belongs to the old stream and must be thrown away.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding - CW'(imem_resp_valid_in);
      discard     <= outstanding - CW'(imem_resp_valid_in);
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid_in);
      if (imem_resp_valid_in) begin
        if (discard != '0) begin
          discard <= discard - 1'b1;
        end else begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
      if (push) begin
        pc_mem[wr_ptr]   <= resp_pc;
        inst_mem[wr_ptr] <= imem_resp_data_in;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch.sv
//==============================================================================
// Module      : tb_riscv_fetch
// Description : Directed bench for riscv_fetch with a fixed-latency in-order
//               instruction memory model and hand-computed expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fault;

  riscv_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .redirect_valid_in  (redirect_valid),
    .redirect_pc_in     (redirect_pc),
    .imem_req_valid_out (req_valid),
    .imem_req_ready_in  (req_ready),
    .imem_req_addr_out  (req_addr),
    .imem_resp_valid_in (resp_valid),
    .imem_resp_data_in  (resp_data),
    .inst_valid_out     (inst_valid),
    .inst_ready_in      (inst_ready),
    .inst_out           (inst),
    .pc_out             (pc),
    .fault_out          (fault)
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          cyc       = 0;
  int          lat       = 1;
  logic        saw_resp;
  logic        saw_pop;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle starting at a negedge: present a due memory response,
  // log request acceptances and decode pops, then advance to the next negedge.
  task automatic cycle();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      saw_resp = 1'b1;
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
      saw_resp   = 1'b0;
    end
    #1;
    saw_pop = inst_valid && inst_ready;
    if (req_valid && req_ready) begin
      mq_addr.push_back(req_addr);
      mq_due.push_back(cyc + lat);
      req_log.push_back(req_addr);
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      pop_pc.push_back(pc);
      pop_inst.push_back(inst);
      pop_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_inst.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    resp_valid     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mq_addr.delete();
    mq_due.delete();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int bad;
    @(negedge clk);

    // ---------------- Reset state ----------------
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    #1;
    check("rst_req_valid",  {31'd0, req_valid},  32'd0);
    check("rst_req_addr",   req_addr,            32'h0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",       inst,                32'h0);
    check("rst_pc",         pc,                  32'h0);
    check("rst_fault",      {31'd0, fault},      32'd0);

    // ---------------- 1: streaming, 1-cycle memory ----------------
    run(12);
    check("t1_pop_count_ge4", {31'd0, pop_pc.size() >= 4}, 32'd1);
    if (pop_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_pc%0d", i),   pop_pc[i],   32'(4 * i));
        check($sformatf("t1_inst%0d", i), pop_inst[i], mem_word(32'(4 * i)));
      end
      for (int i = 1; i < 4; i++) begin
        check($sformatf("t1_back2back%0d", i), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      end
    end

    // ---------------- 2: decode stalled, FIFO fills ----------------
    inst_ready = 1'b0;
    do_reset();
    run(12);
    check("t2_req_count", 32'(req_log.size()), 32'd4);
    #1;
    check("t2_req_valid_low", {31'd0, req_valid},  32'd0);
    check("t2_inst_valid",    {31'd0, inst_valid}, 32'd1);
    check("t2_head_pc",       pc,                  32'h0);
    inst_ready = 1'b1;
    run(12);
    check("t2_pop_count_ge5", {31'd0, pop_pc.size() >= 5}, 32'd1);
    if (pop_pc.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_pc%0d", i), pop_pc[i], 32'(4 * i));
      end
    end
    check("t2_req_ge5", {31'd0, req_log.size() >= 5}, 32'd1);
    if (req_log.size() >= 5) check("t2_resume_addr", req_log[4], 32'h10);

    // ---------------- 3: redirect with 2 outstanding, latency 3 ----------------
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && req_log.size() < 2; i++) cycle();
    check("t3_two_outstanding", 32'(req_log.size()), 32'd2);
    redirect(32'h100);
    run(20);
    check("t3_pops_present", {31'd0, pop_pc.size() > 0}, 32'd1);
    if (pop_pc.size() > 0) begin
      check("t3_first_pc",   pop_pc[0],   32'h100);
      check("t3_first_inst", pop_inst[0], mem_word(32'h100));
    end
    bad = 0;
    foreach (pop_pc[i]) if (pop_pc[i] < 32'h100) bad++;
    check("t3_no_stale", 32'(bad), 32'd0);
    if (req_log.size() >= 3) check("t3_first_req_after", req_log[2], 32'h100);

    // ---------------- 4: redirect coincident with pop and response ----------------
    lat = 1;
    do_reset();
    for (int i = 0; i < 20 && pop_pc.size() < 1; i++) cycle();
    clear_logs();
    redirect(32'h200);
    check("t4_resp_same_cycle", {31'd0, saw_resp}, 32'd1);
    check("t4_pop_same_cycle",  {31'd0, saw_pop},  32'd1);
    #1;
    check("t4_valid_after", {31'd0, inst_valid}, 32'd0);
    run(15);
    check("t4_pops_present", {31'd0, pop_pc.size() > 0}, 32'd1);
    bad = 0;
    foreach (pop_pc[i]) if (pop_pc[i] !== 32'h200 + 32'(4 * i)) bad++;
    check("t4_only_new_stream", 32'(bad), 32'd0);
    if (pop_pc.size() > 0) check("t4_first_pc", pop_pc[0], 32'h200);

    // ---------------- 5: stalled request, back-to-back redirects ----------------
    req_ready = 1'b0;
    do_reset();
    cycle();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      #1;
      if (req_valid !== 1'b1 || req_addr !== 32'h0) bad++;
    end
    check("t5_addr_stable", 32'(bad), 32'd0);
    redirect(32'h40);
    redirect(32'h80);
    req_ready = 1'b1;
    run(6);
    check("t5_req_seen", {31'd0, req_log.size() > 0}, 32'd1);
    if (req_log.size() > 0) check("t5_first_req", req_log[0], 32'h80);

    // ---------------- 6: misaligned redirect ----------------
    do_reset();
    run(4);
    clear_logs();
    redirect(32'h102);
    run(10);
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    #1;
    check("t6_fault_set",  {31'd0, fault}, 32'd1);
    check("t6_no_reqs",    32'(req_log.size()), 32'd0);
    check("t6_no_pops",    32'(pop_pc.size()),  32'd0);
    redirect(32'h104);
    #1;
    check("t6_fault_clear", {31'd0, fault}, 32'd0);
    run(10);
    check("t6_pops_present", {31'd0, pop_pc.size() > 0}, 32'd1);
    if (pop_pc.size() > 0) check("t6_first_pc", pop_pc[0], 32'h104);
`else
    #1;
    check("t6_fault_tied0", {31'd0, fault}, 32'd0);
    check("t6_pops_present", {31'd0, pop_pc.size() > 0}, 32'd1);
    if (pop_pc.size() > 0) check("t6_first_pc", pop_pc[0], 32'h100);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
